// File: rtl/ahfp_add_sub_arb.sv
// Two-requester round-robin front end for a shared, pipelined FP add/sub unit.
// Operands are registered toward the unit, and a {valid,id} tag pipeline
// routes each result back to the requester that issued it.
module ahfp_add_sub_arb #(
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hold,
   input  logic        req0_valid,
   input  logic [31:0] req0_dataa,
   input  logic [31:0] req0_datab,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [31:0] req1_dataa,
   input  logic [31:0] req1_datab,
   output logic        req1_ready,
   output logic [31:0] fu_dataa,
   output logic [31:0] fu_datab,
   input  logic [31:0] fu_result,
   output logic        rsp0_valid,
   output logic [31:0] rsp0_result,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_result
);

   // Bit 0 is the issue stage, loaded together with the operands; bit
   // LATENCY lines up with the unit's result.
   logic [LATENCY:0] vld_q, vld_d;
   logic [LATENCY:0] id_q, id_d;
   logic             ptr_q, ptr_d;   // id of the last granted requester
   logic [31:0]      fa_q, fa_d;
   logic [31:0]      fb_q, fb_d;
   logic             gnt0, gnt1, accept;

   // Round-robin grant: with both valid, the requester not granted last wins.
   always_comb begin
      gnt0   = ~reset & ~hold & req0_valid & (~req1_valid |  ptr_q);
      gnt1   = ~reset & ~hold & req1_valid & (~req0_valid | ~ptr_q);
      accept = gnt0 | gnt1;
   end

   // Next-state for pointer, operand registers and tag pipeline.
   always_comb begin
      ptr_d = ptr_q;
      fa_d  = fa_q;
      fb_d  = fb_q;
      if (accept) begin
         ptr_d = gnt1;
         fa_d  = gnt1 ? req1_dataa : req0_dataa;
         fb_d  = gnt1 ? req1_datab : req0_datab;
      end
      vld_d = {vld_q[LATENCY-1:0], accept};
      id_d  = {id_q[LATENCY-1:0], gnt1};
   end

   // State registers; reset drops all in-flight tags and restores priority to requester 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= 1'b1;
         fa_q  <= '0;
         fb_q  <= '0;
         vld_q <= '0;
         id_q  <= '0;
      end else begin
         ptr_q <= ptr_d;
         fa_q  <= fa_d;
         fb_q  <= fb_d;
         vld_q <= vld_d;
         id_q  <= id_d;
      end
   end

   // Output steering: the result is forwarded only to the tagged requester.
   always_comb begin
      req0_ready  = gnt0;
      req1_ready  = gnt1;
      fu_dataa    = fa_q;
      fu_datab    = fb_q;
      rsp0_valid  = vld_q[LATENCY] & ~id_q[LATENCY];
      rsp1_valid  = vld_q[LATENCY] &  id_q[LATENCY];
      rsp0_result = rsp0_valid ? fu_result : '0;
      rsp1_result = rsp1_valid ? fu_result : '0;
   end

endmodule

// File: tb/tb_ahfp_add_sub_arb.sv
// Bench for ahfp_add_sub_arb: LATENCY=1 and LATENCY=3 instances share one
// requester stimulus; each has its own FU stand-in and response scoreboard.
module tb_ahfp_add_sub_arb;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, hold;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_dataa, req0_datab, req1_dataa, req1_datab;

   logic        l1_r0, l1_r1, l1_v0, l1_v1;
   logic [31:0] l1_fa, l1_fb, l1_d0, l1_d1, f1;
   logic        l3_r0, l3_r1, l3_v0, l3_v1;
   logic [31:0] l3_fa, l3_fb, l3_d0, l3_d1;
   logic [31:0] f3 [0:2];

   ahfp_add_sub_arb #(.LATENCY(1)) u_lat1 (
      .clk(clk), .reset(reset), .hold(hold),
      .req0_valid(req0_valid), .req0_dataa(req0_dataa), .req0_datab(req0_datab), .req0_ready(l1_r0),
      .req1_valid(req1_valid), .req1_dataa(req1_dataa), .req1_datab(req1_datab), .req1_ready(l1_r1),
      .fu_dataa(l1_fa), .fu_datab(l1_fb), .fu_result(f1),
      .rsp0_valid(l1_v0), .rsp0_result(l1_d0), .rsp1_valid(l1_v1), .rsp1_result(l1_d1));

   ahfp_add_sub_arb #(.LATENCY(3)) u_lat3 (
      .clk(clk), .reset(reset), .hold(hold),
      .req0_valid(req0_valid), .req0_dataa(req0_dataa), .req0_datab(req0_datab), .req0_ready(l3_r0),
      .req1_valid(req1_valid), .req1_dataa(req1_dataa), .req1_datab(req1_datab), .req1_ready(l3_r1),
      .fu_dataa(l3_fa), .fu_datab(l3_fb), .fu_result(f3[2]),
      .rsp0_valid(l3_v0), .rsp0_result(l3_d0), .rsp1_valid(l3_v1), .rsp1_result(l3_d1));

   // FU stand-in: 1.0+2.0 gives the true IEEE sum, anything else an integer sum.
   function automatic logic [31:0] fu_model(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      return a + b;
   endfunction

   // Registered FU pipelines of depth 1 and 3.
   always @(posedge clk) begin
      f1    <= fu_model(l1_fa, l1_fb);
      f3[0] <= fu_model(l3_fa, l3_fb);
      f3[1] <= f3[0];
      f3[2] <= f3[1];
   end

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned checks = 0, errors = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, act, exp);
      end
   endtask

   task automatic check_rsp(input string pfx, input logic av0, input logic av1,
                            input logic [31:0] ad0, input logic [31:0] ad1,
                            input logic ev0, input logic ev1, input logic [31:0] er);
      check_val({pfx, "rsp0_valid"},  {31'd0, av0}, {31'd0, ev0});
      check_val({pfx, "rsp1_valid"},  {31'd0, av1}, {31'd0, ev1});
      check_val({pfx, "rsp0_result"}, ad0, ev0 ? er : 32'd0);
      check_val({pfx, "rsp1_result"}, ad1, ev1 ? er : 32'd0);
   endtask

   typedef struct {
      int unsigned due;
      logic        id;
      logic [31:0] res;
   } sb_t;

   sb_t         q1[$], q3[$];
   sb_t         e;
   logic        exp_ptr = 1'b1;
   logic [31:0] exp_fa = '0, exp_fb = '0;
   logic        g0, g1, ev0, ev1;
   logic [31:0] er;
   logic        acc0 = 1'b0, acc1 = 1'b0;

   // Checker and scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset) begin
         q1.delete();
         q3.delete();
         exp_ptr = 1'b1;
         exp_fa  = '0;
         exp_fb  = '0;
         acc0    = 1'b0;
         acc1    = 1'b0;
         check_val("rst L1 ready", {30'd0, l1_r1, l1_r0}, 32'd0);
         check_val("rst L3 ready", {30'd0, l3_r1, l3_r0}, 32'd0);
         check_val("rst L1 fu_dataa", l1_fa, 32'd0);
         check_val("rst L1 fu_datab", l1_fb, 32'd0);
         check_val("rst L3 fu_dataa", l3_fa, 32'd0);
         check_val("rst L3 fu_datab", l3_fb, 32'd0);
         check_rsp("rst L1 ", l1_v0, l1_v1, l1_d0, l1_d1, 1'b0, 1'b0, 32'd0);
         check_rsp("rst L3 ", l3_v0, l3_v1, l3_d0, l3_d1, 1'b0, 1'b0, 32'd0);
      end else begin
         g0 = req0_valid && !hold && (!req1_valid || exp_ptr == 1'b1);
         g1 = req1_valid && !hold && (!req0_valid || exp_ptr == 1'b0);
         check_val("L1 ready", {30'd0, l1_r1, l1_r0}, {30'd0, g1, g0});
         check_val("L3 ready", {30'd0, l3_r1, l3_r0}, {30'd0, g1, g0});
         check_val("L1 fu_dataa", l1_fa, exp_fa);
         check_val("L1 fu_datab", l1_fb, exp_fb);
         check_val("L3 fu_dataa", l3_fa, exp_fa);
         check_val("L3 fu_datab", l3_fb, exp_fb);

         ev0 = 1'b0; ev1 = 1'b0; er = '0;
         if (q1.size() != 0 && q1[0].due == cyc) begin
            e = q1.pop_front(); ev0 = !e.id; ev1 = e.id; er = e.res;
         end
         check_rsp("L1 ", l1_v0, l1_v1, l1_d0, l1_d1, ev0, ev1, er);

         ev0 = 1'b0; ev1 = 1'b0; er = '0;
         if (q3.size() != 0 && q3[0].due == cyc) begin
            e = q3.pop_front(); ev0 = !e.id; ev1 = e.id; er = e.res;
         end
         check_rsp("L3 ", l3_v0, l3_v1, l3_d0, l3_d1, ev0, ev1, er);

         if (g0 || g1) begin
            exp_fa  = g1 ? req1_dataa : req0_dataa;
            exp_fb  = g1 ? req1_datab : req0_datab;
            exp_ptr = g1;
            q1.push_back('{due: cyc + 2, id: g1, res: fu_model(exp_fa, exp_fb)});
            q3.push_back('{due: cyc + 4, id: g1, res: fu_model(exp_fa, exp_fb)});
         end
         acc0 = g0;
         acc1 = g1;
      end
   end

   // One cycle of stimulus; fresh operands only once the previous ones were taken.
   task automatic step(input bit v0, input bit v1, input bit h, input bit r, input bit rnd);
      @(posedge clk);
      #2;
      reset = r;
      hold  = h;
      if (rnd && (acc0 || !req0_valid)) begin
         req0_dataa = $urandom; req0_datab = $urandom;
      end
      if (rnd && (acc1 || !req1_valid)) begin
         req1_dataa = $urandom; req1_datab = $urandom;
      end
      req0_valid = v0;
      req1_valid = v1;
   endtask

   initial begin
      reset = 1'b1; hold = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_dataa = '0; req0_datab = '0; req1_dataa = '0; req1_datab = '0;
      repeat (2) @(posedge clk);
      step(0, 0, 0, 0, 1);

      // single request 1.0 + 2.0
      req0_dataa = 32'h3F80_0000;
      req0_datab = 32'h4000_0000;
      step(1, 0, 0, 0, 0);
      repeat (5) step(0, 0, 0, 0, 1);

      // contention straight after reset
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1);
      repeat (4) step(1, 1, 0, 0, 1);
      repeat (5) step(0, 0, 0, 0, 1);

      // hold with an operation in flight
      step(1, 0, 0, 0, 1);
      repeat (3) step(1, 1, 1, 0, 1);
      repeat (2) step(1, 1, 0, 0, 1);
      repeat (5) step(0, 0, 0, 0, 1);

      // reset with two operations in flight
      repeat (2) step(1, 1, 0, 0, 1);
      step(0, 0, 0, 1, 1);
      repeat (6) step(0, 0, 0, 0, 1);

      // sparse traffic on requester 1
      repeat (5) begin
         step(0, 1, 0, 0, 1);
         step(0, 0, 0, 0, 1);
         step(0, 0, 0, 0, 1);
      end
      repeat (5) step(0, 0, 0, 0, 1);

      // random traffic with occasional hold and reset
      repeat (300) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                        $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0, 1);
      repeat (8) step(0, 0, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahfp_add_sub_arb.md
AHFP_ADD_SUB_ARB -- requirements
Module: ahfp_add_sub_arb

Interface
REQ-001 Parameter: LATENCY, 1, registered latency in clk edges of the shared add/sub unit, from operand change to result change; legal range 1..4.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 hold  input  1  when 1, no new requests are granted; in-flight operations still complete.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_dataa, req0_datab  input  32 each  requester 0 operands, IEEE-754 single precision.
REQ-007 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 req1_valid, req1_dataa, req1_datab, req1_ready  same widths and directions as requester 0, for requester 1.
REQ-009 fu_dataa, fu_datab  output  32 each  operands driven to the shared add/sub unit.
REQ-010 fu_result  input  32  result from the shared add/sub unit.
REQ-011 rsp0_valid, rsp1_valid  output  1 each  result for that requester is present this cycle.
REQ-012 rsp0_result, rsp1_result  output  32 each  result data for that requester.

Function
REQ-013 A request is accepted in a cycle where reqN_valid=1 and reqN_ready=1.
REQ-014 reqN_ready is combinational from reqN_valid, hold, reset and the priority pointer; at most one ready is high per cycle.
REQ-015 Arbitration is round-robin: one valid requester is granted; if both are valid, the requester other than the last granted one wins.
REQ-016 The priority pointer (last granted id) updates only on acceptance; idle cycles leave it unchanged.
REQ-017 hold=1 forces req0_ready=req1_ready=0 and leaves the pointer unchanged.
REQ-018 Requesters keep valid high and operands stable until ready; a deasserted valid before grant withdraws the request with no effect.
REQ-019 On acceptance at edge E, fu_dataa/fu_datab register the granted operands and hold them through the following cycle.
REQ-020 With no acceptance, fu_dataa/fu_datab keep their previous values.
REQ-021 A tag pipeline of LATENCY stages carries {valid, id} from the issue register to response; an idle cycle inserts a bubble (valid=0).
REQ-022 rspN_valid is high for exactly one cycle, during the cycle that begins at edge E+LATENCY, only when the tag id equals N.
REQ-023 rspN_result equals fu_result while rspN_valid=1, else 32'd0.
REQ-024 Throughput is one accepted operation per cycle; responses return in acceptance order, and the two rsp_valid outputs are never high together.
REQ-025 The block performs no floating-point arithmetic and does not modify operand bits.

Reset
REQ-026 While reset=1, pending operations are discarded and never produce a response.
REQ-027 Reset values while reset=1: fu_dataa=fu_datab=32'd0, all tag stages invalid, pointer=1 (requester 0 has first priority), reqN_ready=0, rspN_valid=0, rspN_result=32'd0.
REQ-028 An operation accepted in the cycle reset asserts is discarded.
REQ-029 The first grant is possible in the first cycle with reset=0.

Verification
REQ-030 Single request, LATENCY=1: req0 1.0+2.0 (0x3F800000, 0x40000000) accepted at E -> fu operands equal these values after E; rsp0_valid=1 only in the cycle after E+1, with rsp0_result=fu_result=0x40400000; rsp1_valid stays 0.
REQ-031 Contention: both valid for 4 cycles after reset -> grants 0,1,0,1; responses alternate rsp0, rsp1, rsp0, rsp1 with one per cycle and no gaps.
REQ-032 hold: both valid with hold=1 for 3 cycles -> both ready=0 and pointer unchanged; an operation already in flight still responds on time; after hold falls, the next grant follows the pointer.
REQ-033 Mid-flight reset, LATENCY=3: accept 2 ops, then assert reset for 1 cycle -> no rsp_valid ever appears for them, and outputs equal their REQ-027 values.
REQ-034 Sparse traffic: req1 valid in every third cycle -> rsp1 pulses exactly LATENCY+1 cycles after each accept cycle, bubbles leave rsp_valid=0, and rsp1_result=0 between pulses.
